reg_file_scoreboard: RTL and testbench

- Parametrised register file for the double-accumulator datapath, replacing discrete 16-bit Register instances.
- Two combinational read ports with write-bypass, one byte-enabled write port, and a per-register pending (scoreboard) bit.
- The pending bits let the control unit stall an instruction whose source or destination is still awaiting writeback.
- Sits between the instruction decode fields (reg1/reg2/regDest) and the ALU/accumulator writeback path.

---
 rtl/reg_file_scoreboard.sv | 121 ++++++++++++
 tb/tb_reg_file_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Register file for the double-accumulator datapath. It has two combinational
//   read ports with write-bypass, one byte-enabled writeback port and a
//   per-register pending bit. The control unit uses the pending bits to stall
//   an issue whose destination still awaits writeback.
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-low reset
//   rd_addr_a/b     read addresses
//   rd_data_a/b     read data (combinational, bypassed from same-cycle write)
//   busy_a/b        source still pending and not resolved by this cycle's write
//   wr_en, wr_addr, wr_data, wr_be
//                   writeback strobe, register, data and byte enables
//   issue_en, issue_dest
//                   issue strobe and destination register to mark pending
//   stall           issue rejected this cycle (combinational)
//   busy_vec        registered pending bits
//   pending_count   registered popcount of busy_vec
module reg_file_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic                  busy_a,
  output logic                  busy_b,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_dest,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [ADDR_W:0]       pending_count
);

  localparam int NB = DATA_W / 8;
  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   wr_merged;
  logic                wr_to_zero;
  logic                issue_to_zero;
  logic                issue_ok;
  logic [NUM_REGS-1:0] busy_nxt;

  // Byte i of the result comes from nw when be[i] is set, else from old.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] nw,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + (ADDR_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  // Combinational stage: write merge, bypassed reads, hazard resolution
  assign wr_merged     = byte_merge(regs[wr_addr], wr_data, wr_be);
  assign wr_to_zero    = ZR && (wr_addr == '0);
  assign issue_to_zero = ZR && (issue_dest == '0);

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_merged;
    if (ZR && (rd_addr_a == '0))          rd_data_a = '0;

    rd_data_b = regs[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_merged;
    if (ZR && (rd_addr_b == '0))          rd_data_b = '0;
  end

  // A same-cycle writeback to the register resolves the hazard, so neither
  // the readers nor the issuer see it as busy.
  assign busy_a = busy_vec[rd_addr_a] & ~(wr_en & (wr_addr == rd_addr_a));
  assign busy_b = busy_vec[rd_addr_b] & ~(wr_en & (wr_addr == rd_addr_b));
  assign stall  = issue_en & busy_vec[issue_dest] & ~(wr_en & (wr_addr == issue_dest));

  // Clear on writeback first, then set on issue, so a same-cycle issue wins.
  // The hardwired zero register never becomes pending.
  assign issue_ok = issue_en & ~stall & ~issue_to_zero;

  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en)    busy_nxt[wr_addr]    = 1'b0;
    if (issue_ok) busy_nxt[issue_dest] = 1'b1;
  end

  // Register stage: architectural state and scoreboard
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy_vec      <= '0;
      pending_count <= '0;
    end else begin
      if (wr_en && !wr_to_zero) regs[wr_addr] <= wr_merged;
      busy_vec      <= busy_nxt;
      pending_count <= popcount(busy_nxt);
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int AW = 2;

  logic          CLK;
  logic          RST;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, issue_dest;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_be;
  logic          wr_en, issue_en;

  // Index 0: ZERO_REG=0 instance, index 1: ZERO_REG=1 instance.
  logic [DW-1:0] rd_a [2];
  logic [DW-1:0] rd_b [2];
  logic          bsy_a [2];
  logic          bsy_b [2];
  logic          stl [2];
  logic [NR-1:0] bvec [2];
  logic [AW:0]   pcnt [2];

  reg_file_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a[0]), .rd_data_b(rd_b[0]),
    .busy_a(bsy_a[0]), .busy_b(bsy_b[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .stall(stl[0]), .busy_vec(bvec[0]), .pending_count(pcnt[0])
  );

  reg_file_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
    .CLK(CLK), .RST(RST),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a[1]), .rd_data_b(rd_b[1]),
    .busy_a(bsy_a[1]), .busy_b(bsy_b[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .stall(stl[1]), .busy_vec(bvec[1]), .pending_count(pcnt[1])
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents and pending flags per instance.
  int m_reg  [2][NR];
  bit m_busy [2][NR];
  bit m_valid = 0;

  function automatic int mask_of(input logic [1:0] be);
    return (be[0] ? 32'h00FF : 0) + (be[1] ? 32'hFF00 : 0);
  endfunction

  function automatic int m_written(input int z);
    int m;
    m = mask_of(wr_be);
    return (m_reg[z][wr_addr] & ~m & 32'hFFFF) | (int'(wr_data) & m);
  endfunction

  function automatic int m_read(input int z, input int a);
    if (z == 1 && a == 0) return 0;
    if (wr_en && int'(wr_addr) == a) return m_written(z);
    return m_reg[z][a];
  endfunction

  function automatic bit m_hazard(input int z, input int a);
    return m_busy[z][a] && !(wr_en && int'(wr_addr) == a);
  endfunction

  task automatic cycle();
    bit st;
    int vec, cnt;
    #1;
    if (m_valid) begin
      for (int z = 0; z < 2; z++) begin
        vec = 0; cnt = 0;
        for (int r = 0; r < NR; r++) if (m_busy[z][r]) begin vec += (1 << r); cnt++; end
        chk($sformatf("rd_a%0d", z), rd_a[z], m_read(z, rd_addr_a));
        chk($sformatf("rd_b%0d", z), rd_b[z], m_read(z, rd_addr_b));
        chk($sformatf("busy_a%0d", z), bsy_a[z], m_hazard(z, rd_addr_a));
        chk($sformatf("busy_b%0d", z), bsy_b[z], m_hazard(z, rd_addr_b));
        chk($sformatf("stall%0d", z), stl[z], issue_en && m_hazard(z, issue_dest));
        chk($sformatf("busy_vec%0d", z), bvec[z], vec);
        chk($sformatf("pcount%0d", z), pcnt[z], cnt);
      end
    end
    @(posedge CLK);
    for (int z = 0; z < 2; z++) begin
      if (!RST) begin
        for (int r = 0; r < NR; r++) begin m_reg[z][r] = 0; m_busy[z][r] = 0; end
      end else begin
        st = issue_en && m_hazard(z, issue_dest);
        if (wr_en) begin
          if (!(z == 1 && wr_addr == 0)) m_reg[z][wr_addr] = m_written(z);
          m_busy[z][wr_addr] = 0;
        end
        if (issue_en && !st && !(z == 1 && issue_dest == 0)) m_busy[z][issue_dest] = 1;
      end
    end
    if (!RST) m_valid = 1;
    @(negedge CLK);
  endtask

  task automatic idle();
    wr_en = 0; issue_en = 0; wr_be = 2'b00; wr_data = '0; wr_addr = '0; issue_dest = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  initial begin
    RST = 0; rd_addr_a = '0; rd_addr_b = '0;
    idle();
    @(negedge CLK);
    cycle(); cycle();

    // Reset clears previously written data
    RST = 1; wr(2, 16'hBEEF, 2'b11); cycle();
    idle(); RST = 0; cycle(); cycle();
    RST = 1; rd_addr_a = 2; rd_addr_b = 1;
    #1;
    chk("rst_rd_r2", rd_a[0], 16'h0000);
    chk("rst_busy_vec", bvec[0], 4'b0000);
    chk("rst_pcount", pcnt[0], 0);
    cycle();

    // Byte enables
    wr(1, 16'h1234, 2'b11); cycle();
    wr(1, 16'hAB00, 2'b10); cycle();
    idle(); rd_addr_a = 1;
    #1 chk("be_merge", rd_a[0], 16'hAB34);
    cycle();

    // Bypass
    wr(3, 16'h5A5A, 2'b11); rd_addr_a = 3;
    #1;
    chk("bypass_data", rd_a[0], 16'h5A5A);
    chk("bypass_busy", bsy_a[0], 1'b0);
    cycle();

    // Scoreboard
    idle(); issue_en = 1; issue_dest = 2; cycle();
    idle();
    #1;
    chk("sb_vec", bvec[0], 4'b0100);
    chk("sb_cnt", pcnt[0], 1);
    cycle();
    issue_en = 1; issue_dest = 2;
    #1 chk("sb_stall", stl[0], 1'b1);
    cycle();
    idle();
    #1 chk("sb_stall_keep", bvec[0], 4'b0100);
    wr(2, 16'h0F0F, 2'b11); issue_en = 1; issue_dest = 2;
    #1 chk("sb_resolve_nostall", stl[0], 1'b0);
    cycle();
    idle();
    #1 chk("sb_issue_wins", bvec[0][2], 1'b1);
    cycle();
    wr(2, 16'h0000, 2'b00); cycle();

    // Hardwired zero register
    idle(); rd_addr_a = 0; wr(0, 16'hFFFF, 2'b11); issue_en = 1; issue_dest = 0;
    #1;
    chk("zr_bypass_rd", rd_a[1], 16'h0000);
    chk("zr_stall", stl[1], 1'b0);
    cycle();
    idle(); issue_en = 1; issue_dest = 0;
    #1;
    chk("zr_rd", rd_a[1], 16'h0000);
    chk("zr_busy0", bvec[1][0], 1'b0);
    chk("zr_stall2", stl[1], 1'b0);
    cycle();

    // Full pending then partial writeback
    idle(); RST = 0; cycle(); RST = 1;
    for (int r = 0; r < NR; r++) begin
      idle(); issue_en = 1; issue_dest = AW'(r); cycle();
    end
    idle();
    #1 chk("full_cnt", pcnt[0], 4);
    wr(3, 16'h1111, 2'b11); cycle();
    wr(0, 16'h2222, 2'b01); cycle();
    idle();
    #1;
    chk("part_cnt", pcnt[0], 2);
    chk("part_vec", bvec[0], 4'b0110);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      RST        = ($urandom_range(0, 39) != 0);
      rd_addr_a  = AW'($urandom_range(0, NR-1));
      rd_addr_b  = AW'($urandom_range(0, NR-1));
      wr_en      = $urandom_range(0, 1) == 1;
      wr_addr    = AW'($urandom_range(0, NR-1));
      wr_data    = DW'($urandom);
      wr_be      = 2'($urandom_range(0, 3));
      issue_en   = $urandom_range(0, 1) == 1;
      issue_dest = AW'($urandom_range(0, NR-1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
